fc_mac_array: RTL and testbench



---
 rtl/fc_mac_array.sv | 144 ++++++++++++++
 tb/tb_fc_mac_array.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_mac_array.sv
// Fully-connected MAC engine. Each beat carries N_LANE activations, and an inference lasts STEPS beats.
// The engine accumulates into N_OUT signed neurons from a runtime-writable weight memory and returns the sums over valid/ready.
module fc_mac_array #(
    parameter int IN_W     = 2,
    parameter int N_LANE   = 3,
    parameter int N_OUT    = 2,
    parameter int STEPS    = 36,
    parameter int W_W      = 3,
    parameter int ACC_W    = 10,
    parameter int SATURATE = 1,
    parameter int WA_W     = $clog2(N_OUT * N_LANE * STEPS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_LANE*IN_W-1:0]  in_data,
    input  logic                    wt_we,
    input  logic [WA_W-1:0]         wt_addr,
    input  logic [W_W-1:0]          wt_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N_OUT*ACC_W-1:0]  out_data,
    output logic                    busy,
    output logic                    done
);

    localparam int DEPTH = N_OUT * N_LANE * STEPS;
    localparam int SW    = $clog2(STEPS + 1);
    localparam int PW    = IN_W + W_W + 1;
    localparam int SUM_W = PW + $clog2(N_LANE) + 1;
    localparam int EXT_W = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;
    localparam int WA_W1 = WA_W + 1;

    localparam logic [WA_W:0]            DEPTH_L = WA_W1'(DEPTH);
    localparam logic [SW-1:0]            LAST    = SW'(STEPS - 1);
    localparam logic signed [EXT_W-1:0]  MAXV    = EXT_W'((2 ** (ACC_W - 1)) - 1);
    localparam logic signed [EXT_W-1:0]  MINV    = ~MAXV;

    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

    state_t                        st_q, st_d;
    logic [SW-1:0]                 step_q, step_d;
    logic [N_OUT-1:0][ACC_W-1:0]   acc_q, acc_d, out_q, out_d, beat_acc;

    logic signed [W_W-1:0]         wmem [DEPTH];
    logic                          wr_en;

    logic [IN_W-1:0]               act;
    logic [WA_W-1:0]               widx;
    logic signed [PW-1:0]          act_s, w_s, prod;
    logic signed [SUM_W-1:0]       lane_sum;
    logic signed [ACC_W-1:0]       acc_cur;
    logic signed [EXT_W-1:0]       tot;

    // Weight memory is deliberately outside reset so it survives an abort.
    assign wr_en = (st_q == IDLE) && wt_we && ({1'b0, wt_addr} < DEPTH_L);

    always_ff @(posedge clk) begin
        if (wr_en) wmem[wt_addr] <= wt_data;
    end

    // Candidate accumulator values for a beat at the current step.
    always_comb begin
        beat_acc = acc_q;
        act      = '0;
        widx     = '0;
        act_s    = '0;
        w_s      = '0;
        prod     = '0;
        lane_sum = '0;
        acc_cur  = '0;
        tot      = '0;
        for (int unsigned o = 0; o < N_OUT; o++) begin
            lane_sum = '0;
            for (int unsigned l = 0; l < N_LANE; l++) begin
                act      = in_data[l*IN_W +: IN_W];
                widx     = WA_W'((o * N_LANE + l) * STEPS) + WA_W'(step_q);
                act_s    = {{(PW-IN_W){1'b0}}, act};
                w_s      = {{(PW-W_W){wmem[widx][W_W-1]}}, wmem[widx]};
                prod     = act_s * w_s;
                lane_sum = lane_sum + {{(SUM_W-PW){prod[PW-1]}}, prod};
            end
            acc_cur = acc_q[o];
            tot     = {{(EXT_W-ACC_W){acc_cur[ACC_W-1]}}, acc_cur}
                    + {{(EXT_W-SUM_W){lane_sum[SUM_W-1]}}, lane_sum};
            if (SATURATE != 0 && tot > MAXV)      beat_acc[o] = MAXV[ACC_W-1:0];
            else if (SATURATE != 0 && tot < MINV) beat_acc[o] = MINV[ACC_W-1:0];
            else                                  beat_acc[o] = tot[ACC_W-1:0];
        end
    end

    always_comb begin
        st_d   = st_q;
        step_d = step_q;
        acc_d  = acc_q;
        out_d  = out_q;
        case (st_q)
            IDLE: begin
                if (start) begin
                    st_d   = ACC;
                    step_d = '0;
                    acc_d  = '0;
                end
            end
            ACC: begin
                if (in_valid) begin
                    acc_d  = beat_acc;
                    step_d = step_q + SW'(1);
                    if (step_q == LAST) begin
                        st_d  = HOLD;
                        out_d = beat_acc;
                    end
                end
            end
            HOLD: begin
                if (out_ready) st_d = IDLE;
            end
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q   <= IDLE;
            step_q <= '0;
            acc_q  <= '0;
            out_q  <= '0;
        end else begin
            st_q   <= st_d;
            step_q <= step_d;
            acc_q  <= acc_d;
            out_q  <= out_d;
        end
    end

    assign in_ready  = (st_q == ACC);
    assign out_valid = (st_q == HOLD);
    assign busy      = (st_q != IDLE);
    assign done      = out_valid && out_ready;
    assign out_data  = out_q;

endmodule

// File: tb/tb_fc_mac_array.sv
// Bench for fc_mac_array: a saturating and a wrapping instance share stimulus.
// Expected sums are queued at start and compared when the result handshake occurs.
module tb_fc_mac_array;

    localparam int STEPS = 36;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        wt_we = 1'b0;
    logic        out_ready = 1'b1;
    logic [5:0]  in_data = '0;
    logic [7:0]  wt_addr = '0;
    logic [2:0]  wt_data = '0;

    logic        in_ready_s, out_valid_s, busy_s, done_s;
    logic        in_ready_w, out_valid_w, busy_w, done_w;
    logic [19:0] out_s, out_w;

    always #5 clk = ~clk;

    fc_mac_array #(.SATURATE(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_data(in_data), .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_s),
        .busy(busy_s), .done(done_s)
    );

    fc_mac_array #(.SATURATE(0)) dut_w (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready_w),
        .in_data(in_data), .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
        .out_valid(out_valid_w), .out_ready(out_ready), .out_data(out_w),
        .busy(busy_w), .done(done_w)
    );

    typedef struct {
        string      name;
        int         kind;
        logic [5:0] d;
        bit         tog;
        int         e0s, e1s, e0w, e1w;
    } vec_t;

    typedef struct {
        string name;
        int    e0s, e1s, e0w, e1w;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    function automatic int sx(input logic [9:0] v);
        return int'($signed(v));
    endfunction

    function automatic logic [2:0] wfun(input int kind, input int o, input int l, input int s);
        int v;
        case (kind)
            0:       v = 1;
            1:       v = (o == 0) ? 1 : -1;
            2:       v = (o == 0) ? 3 : -4;
            3:       v = (o == 0) ? 2 : -3;
            default: v = (o == 0) ? (l - 1) : ((s < 18) ? 1 : -1);
        endcase
        return v[2:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int kind);
        for (int o = 0; o < 2; o++)
            for (int l = 0; l < 3; l++)
                for (int s = 0; s < STEPS; s++) begin
                    wt_we   = 1'b1;
                    wt_addr = 8'((o * 3 + l) * STEPS + s);
                    wt_data = wfun(kind, o, l, s);
                    tick();
                end
        wt_we = 1'b0;
    endtask

    // Drive beats until out_valid rises or max_beats are accepted; lat = cycles from last beat to out_valid.
    task automatic feed(input logic [5:0] d, input bit tog, input int max_beats,
                        output int beats, output bit saw, output int lat);
        int cyc  = 0;
        int last = -100;
        beats = 0;
        saw   = 1'b0;
        lat   = -1;
        in_data = d;
        while (!saw && beats < max_beats && cyc < 400) begin
            in_valid = tog ? ((cyc % 2) == 0) : 1'b1;
            if (in_valid && in_ready_s) begin
                beats++;
                last = cyc;
            end
            tick();
            cyc++;
            if (out_valid_s) begin
                saw = 1'b1;
                lat = cyc - last;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (busy_s && n < 200) begin
            tick();
            n++;
        end
        chk({nm, " back to idle"}, int'(busy_s), 0);
    endtask

    task automatic push(input string nm, input int e0s, input int e1s, input int e0w, input int e1w);
        exp_t e;
        e.name = nm;
        e.e0s  = e0s;
        e.e1s  = e1s;
        e.e0w  = e0w;
        e.e1w  = e1w;
        sbq.push_back(e);
    endtask

    task automatic finish_run(input string nm, input logic [5:0] d, input bit tog);
        int beats, lat;
        bit saw;
        feed(d, tog, 1000, beats, saw, lat);
        chk({nm, " beats"}, beats, STEPS);
        chk({nm, " latency"}, lat, 1);
        wait_idle(nm);
    endtask

    task automatic run(input string nm, input logic [5:0] d, input bit tog,
                       input int e0s, input int e1s, input int e0w, input int e1w);
        push(nm, e0s, e1s, e0w, e1w);
        start = 1'b1;
        tick();
        start = 1'b0;
        finish_run(nm, d, tog);
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && out_valid_s) begin
            chk("in_ready low in HOLD", int'(in_ready_s), 0);
            if (out_ready) begin
                chk("done on handshake", int'(done_s), 1);
                chk("wrap out_valid", int'(out_valid_w), 1);
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected result: got %0d,%0d want none", sx(out_s[9:0]), sx(out_s[19:10]));
                end else begin
                    e = sbq.pop_front();
                    chk({e.name, " n0 sat"},  sx(out_s[9:0]),   e.e0s);
                    chk({e.name, " n1 sat"},  sx(out_s[19:10]), e.e1s);
                    chk({e.name, " n0 wrap"}, sx(out_w[9:0]),   e.e0w);
                    chk({e.name, " n1 wrap"}, sx(out_w[19:10]), e.e1w);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[6];
        int   beats, lat;
        bit   saw;

        vt[0] = '{"all +1 lanes 3",   0, 6'h3F, 1'b0, 324, 324, 324, 324};
        vt[1] = '{"+1/-1 toggling",   1, 6'h15, 1'b1, 108, -108, 108, -108};
        vt[2] = '{"+3/-4 overflow",   2, 6'h3F, 1'b0, 511, -512, -52, -272};
        vt[3] = '{"+2/-3 lanes 123",  3, 6'h39, 1'b0, 432, -512, 432, 376};
        vt[4] = '{"lane/step weights",4, 6'h39, 1'b0, 72, 0, 72, 0};
        vt[5] = '{"zero activations", 1, 6'h00, 1'b1, 0, 0, 0, 0};

        tick();
        tick();
        chk("reset in_ready",  int'(in_ready_s),  0);
        chk("reset out_valid", int'(out_valid_s), 0);
        chk("reset busy",      int'(busy_s),      0);
        chk("reset done",      int'(done_s),      0);
        chk("reset out_data",  int'(out_s),       0);
        chk("reset wrap out_data", int'(out_w),   0);
        rst_n = 1'b1;
        tick();

        foreach (vt[i]) begin
            load(vt[i].kind);
            run(vt[i].name, vt[i].d, vt[i].tog, vt[i].e0s, vt[i].e1s, vt[i].e0w, vt[i].e1w);
        end

        // Output back-pressure: result must sit still in HOLD.
        load(0);
        out_ready = 1'b0;
        push("stall", 324, 324, 324, 324);
        start = 1'b1;
        tick();
        start = 1'b0;
        feed(6'h3F, 1'b0, 1000, beats, saw, lat);
        chk("stall beats", beats, STEPS);
        chk("stall latency", lat, 1);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("stall out_valid", int'(out_valid_s), 1);
            chk("stall done", int'(done_s), 0);
            chk("stall n0 held", sx(out_s[9:0]), 324);
            chk("stall n1 held", sx(out_s[19:10]), 324);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("stall release done", int'(done_s), 1);
        tick();
        chk("after release out_valid", int'(out_valid_s), 0);
        chk("after release busy", int'(busy_s), 0);
        chk("idle retains n0", sx(out_s[9:0]), 324);
        chk("idle retains n1", sx(out_s[19:10]), 324);
        in_valid = 1'b0;
        tick();

        // Weight write and start during ACC are ignored.
        push("write in ACC", 324, 324, 324, 324);
        start = 1'b1;
        tick();
        start = 1'b0;
        feed(6'h3F, 1'b0, 5, beats, saw, lat);
        chk("write in ACC first beats", beats, 5);
        wt_we   = 1'b1;
        wt_addr = 8'd0;
        wt_data = 3'b100;
        start   = 1'b1;
        tick();
        wt_we = 1'b0;
        start = 1'b0;
        feed(6'h3F, 1'b0, 1000, beats, saw, lat);
        chk("write in ACC rest beats", beats, STEPS - 5);
        chk("write in ACC latency", lat, 1);
        wait_idle("write in ACC");
        run("after ACC write", 6'h3F, 1'b0, 324, 324, 324, 324);

        wt_we   = 1'b1;
        wt_data = 3'b100;
        wt_addr = 8'd216;
        tick();
        wt_addr = 8'd255;
        tick();
        wt_we = 1'b0;
        run("after oob write", 6'h3F, 1'b0, 324, 324, 324, 324);

        // Write coinciding with start lands before the first beat.
        push("write with start", 318, 324, 318, 324);
        wt_we   = 1'b1;
        wt_addr = 8'd0;
        wt_data = 3'b111;
        start   = 1'b1;
        tick();
        wt_we = 1'b0;
        start = 1'b0;
        finish_run("write with start", 6'h3F, 1'b0);

        // Mid-run reset aborts; weights persist.
        load(0);
        start = 1'b1;
        tick();
        start = 1'b0;
        feed(6'h3F, 1'b0, 10, beats, saw, lat);
        chk("pre-abort beats", beats, 10);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort busy", int'(busy_s), 0);
        chk("abort out_valid", int'(out_valid_s), 0);
        chk("abort in_ready", int'(in_ready_s), 0);
        chk("abort out_data", int'(out_s), 0);
        tick();
        chk("abort stays idle", int'(busy_s), 0);
        run("after abort", 6'h3F, 1'b0, 324, 324, 324, 324);

        chk("scoreboard drained", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
